// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Y86-64 style fetch stage with decode, PC steering and halt/error FSM
//
// Purpose: decodes the ten instruction bytes presented at pc_o, registers the
// decoded fields one cycle later and steers the PC (sequential, jump/call
// target, redirect). Returns park the unit in WAIT_RET until a redirect.
//
// Ports:
//   clk_i          clock, all state updates on rising edge
//   rst_i          synchronous active-high reset (overrides everything)
//   stall_i        hold PC, state and all registered outputs
//   redirect_i     load redirect_pc_i and resume in RUN (overrides stall_i)
//   redirect_pc_i  corrected fetch address
//   instr_i        ten bytes at pc_o, byte k = instr_i[8k+7:8k]
//   imem_error_i   pc_o outside memory
//   pc_o           fetch address (PC register)
//   icode_o, ifun_o, rA_o, rB_o, valC_o, valP_o   registered decoded fields
//   valid_o        registered fields hold a real instruction
//   stat_o         0 AOK, 1 HLT, 2 ADR, 3 INS
//   halted_o       high while in HALT or ERR

module fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [63:0] redirect_pc_i,
   input  logic [79:0] instr_i,
   input  logic        imem_error_i,
   output logic [63:0] pc_o,
   output logic [3:0]  icode_o,
   output logic [3:0]  ifun_o,
   output logic [3:0]  rA_o,
   output logic [3:0]  rB_o,
   output logic [63:0] valC_o,
   output logic [63:0] valP_o,
   output logic        valid_o,
   output logic [1:0]  stat_o,
   output logic        halted_o
);

   typedef enum logic [1:0] {S_RUN, S_WAIT_RET, S_HALT, S_ERR} state_t;

   localparam logic [1:0] STAT_AOK = 2'd0;
   localparam logic [1:0] STAT_HLT = 2'd1;
   localparam logic [1:0] STAT_ADR = 2'd2;
   localparam logic [1:0] STAT_INS = 2'd3;

   state_t      r_state;
   logic [63:0] r_pc;
   logic [3:0]  r_icode, r_ifun, r_ra, r_rb;
   logic [63:0] r_valc, r_valp;
   logic        r_valid;
   logic [1:0]  r_stat;

   // combinational decode of the bytes at r_pc
   logic [3:0]  w_icode, w_ifun, w_ra, w_rb, w_len;
   logic        w_need_regids, w_need_valc, w_invalid;
   logic [63:0] w_valc, w_valp;

   // next-state values
   state_t      w_nxt_state;
   logic [63:0] w_nxt_pc, w_nxt_valc, w_nxt_valp;
   logic [3:0]  w_nxt_icode, w_nxt_ifun, w_nxt_ra, w_nxt_rb;
   logic        w_nxt_valid;
   logic [1:0]  w_nxt_stat;

   always_comb begin
      w_icode       = instr_i[7:4];
      w_ifun        = instr_i[3:0];
      w_need_regids = 1'b0;
      w_need_valc   = 1'b0;
      w_len         = 4'd1;
      case (w_icode)
         4'h2, 4'h6, 4'hA, 4'hB: begin
            w_need_regids = 1'b1;
            w_len         = 4'd2;
         end
         4'h3, 4'h4, 4'h5: begin
            w_need_regids = 1'b1;
            w_need_valc   = 1'b1;
            w_len         = 4'd10;
         end
         4'h7, 4'h8: begin
            w_need_valc = 1'b1;
            w_len       = 4'd9;
         end
         default: ;
      endcase
      // icodes C..F are undefined; they keep the default length of 1
      w_invalid = w_icode[3] & w_icode[2];
      w_ra      = w_need_regids ? instr_i[15:12] : 4'hF;
      w_rb      = w_need_regids ? instr_i[11:8]  : 4'hF;
      // the constant follows the regid byte when one is present
      if (!w_need_valc)
         w_valc = 64'h0;
      else if (w_need_regids)
         w_valc = instr_i[79:16];
      else
         w_valc = instr_i[71:8];
      w_valp = r_pc + {60'h0, w_len};
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_pc    = r_pc;
      w_nxt_icode = r_icode;
      w_nxt_ifun  = r_ifun;
      w_nxt_ra    = r_ra;
      w_nxt_rb    = r_rb;
      w_nxt_valc  = r_valc;
      w_nxt_valp  = r_valp;
      w_nxt_valid = r_valid;
      w_nxt_stat  = r_stat;
      if (redirect_i) begin
         w_nxt_state = S_RUN;
         w_nxt_pc    = redirect_pc_i;
         w_nxt_valid = 1'b0;
         w_nxt_stat  = STAT_AOK;
      end else if (!stall_i) begin
         case (r_state)
            S_RUN: begin
               w_nxt_icode = w_icode;
               w_nxt_ifun  = w_ifun;
               w_nxt_ra    = w_ra;
               w_nxt_rb    = w_rb;
               w_nxt_valc  = w_valc;
               w_nxt_valp  = w_valp;
               w_nxt_valid = 1'b1;
               w_nxt_stat  = STAT_AOK;
               w_nxt_pc    = w_valp;
               // address error outranks illegal opcode and halt
               if (imem_error_i) begin
                  w_nxt_stat  = STAT_ADR;
                  w_nxt_state = S_ERR;
                  w_nxt_pc    = r_pc;
               end else if (w_invalid) begin
                  w_nxt_stat  = STAT_INS;
                  w_nxt_state = S_ERR;
                  w_nxt_pc    = r_pc;
               end else if (w_icode == 4'h0) begin
                  w_nxt_stat  = STAT_HLT;
                  w_nxt_state = S_HALT;
                  w_nxt_pc    = r_pc;
               end else if (w_icode == 4'h9) begin
                  // return target is unknown until the redirect arrives
                  w_nxt_state = S_WAIT_RET;
               end else if (w_icode == 4'h7 || w_icode == 4'h8) begin
                  // jumps are predicted taken, calls always go to valC
                  w_nxt_pc = w_valc;
               end
            end
            default: begin
               w_nxt_valid = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_RUN;
         r_pc    <= RESET_PC;
         r_icode <= 4'h0;
         r_ifun  <= 4'h0;
         r_ra    <= 4'h0;
         r_rb    <= 4'h0;
         r_valc  <= 64'h0;
         r_valp  <= 64'h0;
         r_valid <= 1'b0;
         r_stat  <= STAT_AOK;
      end else begin
         r_state <= w_nxt_state;
         r_pc    <= w_nxt_pc;
         r_icode <= w_nxt_icode;
         r_ifun  <= w_nxt_ifun;
         r_ra    <= w_nxt_ra;
         r_rb    <= w_nxt_rb;
         r_valc  <= w_nxt_valc;
         r_valp  <= w_nxt_valp;
         r_valid <= w_nxt_valid;
         r_stat  <= w_nxt_stat;
      end
   end

   assign pc_o     = r_pc;
   assign icode_o  = r_icode;
   assign ifun_o   = r_ifun;
   assign rA_o     = r_ra;
   assign rB_o     = r_rb;
   assign valC_o   = r_valc;
   assign valP_o   = r_valp;
   assign valid_o  = r_valid;
   assign stat_o   = r_stat;
   assign halted_o = (r_state == S_HALT) || (r_state == S_ERR);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized self-checking bench for fetch_unit

module tb_fetch_unit;

   logic        clk_i = 1'b0;
   logic        rst_i, stall_i, redirect_i, imem_error_i;
   logic [63:0] redirect_pc_i;
   logic [79:0] instr_i;
   logic [63:0] pc_o, valC_o, valP_o;
   logic [3:0]  icode_o, ifun_o, rA_o, rB_o;
   logic        valid_o, halted_o;
   logic [1:0]  stat_o;

   int n_cmp = 0;
   int n_bad = 0;

   fetch_unit dut (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i), .instr_i(instr_i), .imem_error_i(imem_error_i),
      .pc_o(pc_o), .icode_o(icode_o), .ifun_o(ifun_o), .rA_o(rA_o), .rB_o(rB_o),
      .valC_o(valC_o), .valP_o(valP_o), .valid_o(valid_o), .stat_o(stat_o),
      .halted_o(halted_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_instr(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
      instr_i = {48'h0, b3, b2, b1, b0};
   endtask

   // reference model: instruction set rules expressed as plain tables/arithmetic
   localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2, M_ERR = 3;
   logic [7:0]  mem [256];
   logic [7:0]  cur [10];
   int          m_mode;
   logic [63:0] m_pc, m_valc, m_valp;
   int          m_icode, m_ifun, m_ra, m_rb, m_stat;
   bit          m_valid;

   function automatic int ref_len(input int ic);
      if (ic inside {3, 4, 5}) return 10;
      if (ic inside {7, 8})    return 9;
      if (ic inside {2, 6, 10, 11}) return 2;
      return 1;
   endfunction

   function automatic bit ref_regs(input int ic);
      return ic inside {2, 3, 4, 5, 6, 10, 11};
   endfunction

   function automatic logic [63:0] ref_const(input int ic);
      logic [63:0] v = 64'h0;
      int off = ref_regs(ic) ? 2 : 1;
      if (!(ic inside {3, 4, 5, 7, 8})) return 64'h0;
      for (int k = 0; k < 8; k++) v = v + (64'(cur[off + k]) << (8 * k));
      return v;
   endfunction

   task automatic model_edge(input bit rst, input bit redir, input logic [63:0] rpc,
                             input bit stl, input bit err);
      int ic;
      if (rst) begin
         m_mode = M_RUN; m_pc = 64'h0; m_valid = 0; m_stat = 0;
         m_icode = 0; m_ifun = 0; m_ra = 0; m_rb = 0; m_valc = 0; m_valp = 0;
      end else if (redir) begin
         m_mode = M_RUN; m_pc = rpc; m_valid = 0; m_stat = 0;
      end else if (stl) begin
         // frozen
      end else if (m_mode != M_RUN) begin
         m_valid = 0;
      end else begin
         ic      = int'(cur[0]) / 16;
         m_icode = ic;
         m_ifun  = int'(cur[0]) % 16;
         m_ra    = ref_regs(ic) ? int'(cur[1]) / 16 : 15;
         m_rb    = ref_regs(ic) ? int'(cur[1]) % 16 : 15;
         m_valc  = ref_const(ic);
         m_valp  = m_pc + 64'(ref_len(ic));
         m_valid = 1;
         m_stat  = 0;
         if (err)           begin m_stat = 2; m_mode = M_ERR;  end
         else if (ic >= 12) begin m_stat = 3; m_mode = M_ERR;  end
         else if (ic == 0)  begin m_stat = 1; m_mode = M_HALT; end
         else if (ic == 9)  begin m_pc = m_valp; m_mode = M_WAIT; end
         else if (ic == 7 || ic == 8) m_pc = m_valc;
         else m_pc = m_valp;
      end
   endtask

   initial begin
      bit          r_rst, r_red, r_stl, r_err;
      logic [63:0] r_rpc;
      int          ic;

      rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; imem_error_i = 1'b0;
      redirect_pc_i = 64'h0; instr_i = 80'h0;

      // reset state
      tick();
      chk("rst_pc", pc_o, 64'h0);
      chk("rst_valid", 64'(valid_o), 64'h0);
      chk("rst_stat", 64'(stat_o), 64'h0);
      chk("rst_halted", 64'(halted_o), 64'h0);
      chk("rst_icode", 64'(icode_o), 64'h0);
      chk("rst_rA", 64'(rA_o), 64'h0);
      chk("rst_valC", valC_o, 64'h0);
      chk("rst_valP", valP_o, 64'h0);

      // irmovq-style instruction with regids and 8-byte constant
      rst_i = 1'b0;
      set_instr(8'h30, 8'hF4, 8'h00, 8'h02);
      tick();
      chk("i3_icode", 64'(icode_o), 64'h3);
      chk("i3_ifun", 64'(ifun_o), 64'h0);
      chk("i3_rA", 64'(rA_o), 64'hF);
      chk("i3_rB", 64'(rB_o), 64'h4);
      chk("i3_valC", valC_o, 64'h200);
      chk("i3_valP", valP_o, 64'h0A);
      chk("i3_valid", 64'(valid_o), 64'h1);
      chk("i3_pc", pc_o, 64'h0A);

      // call
      set_instr(8'h80, 8'h38, 8'h00, 8'h00);
      tick();
      chk("call_valC", valC_o, 64'h38);
      chk("call_valP", valP_o, 64'h13);
      chk("call_rA", 64'(rA_o), 64'hF);
      chk("call_pc", pc_o, 64'h38);

      redirect_i = 1'b1; redirect_pc_i = 64'h85;
      tick();
      chk("redir85_pc", pc_o, 64'h85);
      chk("redir85_valid", 64'(valid_o), 64'h0);
      redirect_i = 1'b0;
      set_instr(8'h71, 8'h90, 8'h00, 8'h00);
      tick();
      chk("jmp_pc", pc_o, 64'h90);
      chk("jmp_ifun", 64'(ifun_o), 64'h1);

      // stall freezes everything
      stall_i = 1'b1;
      set_instr(8'h30, 8'hF4, 8'h00, 8'h02);
      tick();
      chk("stall_pc", pc_o, 64'h90);
      chk("stall_valid", 64'(valid_o), 64'h1);
      chk("stall_icode", 64'(icode_o), 64'h7);
      stall_i = 1'b0;

      redirect_i = 1'b1; redirect_pc_i = 64'h8E;
      tick();
      chk("redir8E_pc", pc_o, 64'h8E);
      chk("redir8E_valid", 64'(valid_o), 64'h0);

      // ret waits for redirect
      redirect_pc_i = 64'h55;
      tick();
      redirect_i = 1'b0;
      set_instr(8'h90, 8'h00, 8'h00, 8'h00);
      tick();
      chk("ret_valid", 64'(valid_o), 64'h1);
      chk("ret_valP", valP_o, 64'h56);
      chk("ret_halted", 64'(halted_o), 64'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wait_valid", 64'(valid_o), 64'h0);
         chk("wait_pc", pc_o, 64'h56);
      end
      redirect_i = 1'b1; redirect_pc_i = 64'h13;
      tick();
      chk("retres_pc", pc_o, 64'h13);
      redirect_i = 1'b0;

      // halt
      set_instr(8'h00, 8'h00, 8'h00, 8'h00);
      tick();
      chk("hlt_stat", 64'(stat_o), 64'h1);
      chk("hlt_halted", 64'(halted_o), 64'h1);
      chk("hlt_valid", 64'(valid_o), 64'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hlt_pc", pc_o, 64'h13);
         chk("hlt_valid_off", 64'(valid_o), 64'h0);
         chk("hlt_stat_hold", 64'(stat_o), 64'h1);
      end
      stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 64'h20;
      tick();
      chk("stallredir_pc", pc_o, 64'h20);
      chk("stallredir_halted", 64'(halted_o), 64'h0);
      chk("stallredir_stat", 64'(stat_o), 64'h0);
      stall_i = 1'b0; redirect_i = 1'b0;

      // address error outranks invalid opcode
      imem_error_i = 1'b1;
      set_instr(8'hC0, 8'h00, 8'h00, 8'h00);
      tick();
      chk("adr_stat", 64'(stat_o), 64'h2);
      chk("adr_valid", 64'(valid_o), 64'h1);
      chk("adr_halted", 64'(halted_o), 64'h1);
      imem_error_i = 1'b0;

      // reset overrides redirect and clears ERR
      rst_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 64'h77;
      tick();
      chk("rsterr_pc", pc_o, 64'h0);
      chk("rsterr_halted", 64'(halted_o), 64'h0);
      chk("rsterr_stat", 64'(stat_o), 64'h0);
      rst_i = 1'b0;
      redirect_pc_i = 64'h30;
      tick();
      redirect_i = 1'b0;
      tick();
      chk("ins_stat", 64'(stat_o), 64'h3);
      chk("ins_valP", valP_o, 64'h31);
      chk("ins_halted", 64'(halted_o), 64'h1);

      // valP wraps modulo 2^64
      redirect_i = 1'b1; redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFE;
      tick();
      redirect_i = 1'b0;
      set_instr(8'h30, 8'hF4, 8'h00, 8'h02);
      tick();
      chk("wrap_valP", valP_o, 64'h8);
      chk("wrap_pc", pc_o, 64'h8);

      // randomized phase against the reference model
      for (int a = 0; a < 256; a++) begin
         ic = ($urandom_range(0, 99) < 85) ? int'($urandom_range(1, 11)) : int'($urandom_range(0, 15));
         mem[a] = 8'((ic * 16) + int'($urandom_range(0, 15)));
      end
      m_pc = 64'h0; m_mode = M_RUN;
      for (int it = 0; it < 3000; it++) begin
         r_rst = (it == 0) || ($urandom_range(0, 99) == 0);
         r_red = ($urandom_range(0, 7) == 0);
         r_stl = ($urandom_range(0, 4) == 0);
         r_rpc = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 255));
         r_err = (m_pc > 64'd245);
         for (int k = 0; k < 10; k++) cur[k] = mem[(int'(m_pc[7:0]) + k) % 256];
         rst_i = r_rst; redirect_i = r_red; stall_i = r_stl; redirect_pc_i = r_rpc;
         imem_error_i = r_err;
         instr_i = {cur[9], cur[8], cur[7], cur[6], cur[5], cur[4], cur[3], cur[2], cur[1], cur[0]};
         model_edge(r_rst, r_red, r_rpc, r_stl, r_err);
         tick();
         chk("rnd_pc", pc_o, m_pc);
         chk("rnd_valid", 64'(valid_o), 64'(m_valid));
         chk("rnd_stat", 64'(stat_o), 64'(m_stat));
         chk("rnd_halted", 64'(halted_o), 64'(m_mode == M_HALT || m_mode == M_ERR));
         if (m_valid) begin
            chk("rnd_icode", 64'(icode_o), 64'(m_icode));
            chk("rnd_ifun", 64'(ifun_o), 64'(m_ifun));
            chk("rnd_rA", 64'(rA_o), 64'(m_ra));
            chk("rnd_rB", 64'(rB_o), 64'(m_rb));
            chk("rnd_valC", valC_o, m_valc);
            chk("rnd_valP", valP_o, m_valp);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 SHALL have port clk_i, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-004 SHALL have port stall_i, input, 1, hold PC, state and all registered outputs.
REQ-005 SHALL have port redirect_i, input, 1, mispredict or ret resolution; load redirect_pc_i.
REQ-006 SHALL have port redirect_pc_i, input, 64, corrected fetch address.
REQ-007 SHALL have port instr_i, input, 80, ten instruction bytes at pc_o, little-endian: byte k = instr_i[8k+7:8k].
REQ-008 SHALL have port imem_error_i, input, 1, pc_o out of memory range.
REQ-009 SHALL have port pc_o, output, 64, fetch address driven from the PC register to memory addr.
REQ-010 SHALL have ports icode_o/ifun_o/rA_o/rB_o, outputs, 4 each, registered decoded fields.
REQ-011 SHALL have ports valC_o and valP_o, outputs, 64 each, registered constant and next-sequential PC.
REQ-012 SHALL have port valid_o, output, 1, registered fields hold a real instruction (0 = bubble).
REQ-013 SHALL have port stat_o, output, 2, status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
REQ-014 SHALL have port halted_o, output, 1, high while in HALT or ERR.

Function
REQ-015 Decode SHALL be combinational from instr_i in the same cycle as pc_o: icode=byte0[7:4], ifun=byte0[3:0].
REQ-016 Regids needed for icode 2,3,4,5,6,A,B: rA=byte1[7:4], rB=byte1[3:0]; otherwise rA=rB=4'hF.
REQ-017 valC SHALL be bytes 2..9 when regids are needed, bytes 1..8 otherwise; 0 for icodes without constant (0,1,2,6,9,A,B).
REQ-018 Length: icode 0,1,9 = 1; 2,6,A,B = 2; 3,4,5 = 10; 7,8 = 9; valP = PC + length, modulo 2^64.
REQ-019 Icode C..F SHALL be invalid; its length is 1.
REQ-020 FSM states: RUN, WAIT_RET, HALT, ERR.
REQ-021 RUN, no stall: register decoded fields, valid_o<=1, stat_o<=AOK; next PC = valC for icode 7 (all ifun, predicted taken) and 8, else valP.
REQ-022 RUN, icode 9: emit with valid_o<=1, PC<=valP, go WAIT_RET.
REQ-023 WAIT_RET: valid_o<=0 each cycle, PC held, until redirect_i.
REQ-024 RUN, icode 0: emit with stat_o<=HLT, go HALT; PC held.
REQ-025 RUN, imem_error_i=1: emit valid_o<=1, stat_o<=ADR, go ERR; takes precedence over INS and HLT.
REQ-026 RUN, invalid icode: emit valid_o<=1, stat_o<=INS, go ERR.
REQ-027 HALT/ERR: valid_o<=0, PC and stat_o held, halted_o=1.
REQ-028 redirect_i=1 in any state: PC<=redirect_pc_i, state<=RUN, valid_o<=0, stat_o<=AOK; overrides stall_i.
REQ-029 stall_i=1 without redirect: nothing changes, including valid_o.
REQ-030 Latency: fields for the instruction at PC appear on outputs one cycle after pc_o shows PC.

Reset
REQ-031 rst_i SHALL override redirect_i and stall_i.
REQ-032 On reset: PC=RESET_PC, state=RUN, valid_o=0, stat_o=AOK, halted_o=0, all field outputs 0.
REQ-033 Reset mid-WAIT_RET/HALT/ERR SHALL return to RUN at RESET_PC with no residual state.

Verification
REQ-034 Reset, instr_i bytes 30 F4 00 02 00.. -> next cycle icode 3, ifun 0, rA F, rB 4, valC 0x200, valP 0x0A, valid 1; pc_o 0x0A.
REQ-035 pc 0x0A, bytes 80 38 00.. -> valC 0x38, valP 0x13, pc_o 0x38; at pc 0x85 bytes 71 90 00.. -> pc_o 0x90; redirect_pc_i 0x8E -> pc_o 0x8E, valid_o 0.
REQ-036 pc 0x55, byte 90 -> valid 1, valP 0x56; valid_o 0 for 3 cycles; redirect_pc_i 0x13 -> pc_o 0x13, state RUN.
REQ-037 pc 0x13, byte 00 -> stat HLT, halted_o 1, pc_o stays 0x13 for 5 cycles; stall_i plus redirect_i together -> redirect wins.
REQ-038 imem_error_i=1 with byte C0 -> stat ADR (not INS), ERR; separately byte C0 alone -> stat INS, valP = PC+1.
